// File: rtl/req_encoder64_6.sv
// Request-vector encoder: accepts a 64-bit request vector and emits the index of
// each set bit in ascending order, one per output handshake.
module req_encoder64_6 #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  idx,
    output logic              last,
    output logic [IDX_W:0]    remaining,
    output logic              busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   pending;
    logic [IDX_W:0]      remaining_q;
    logic [IDX_W-1:0]    scan_idx;

    // Scanning from the top down leaves the lowest set bit as the final winner.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [DATA_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = i[IDX_W-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [DATA_W-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign scan_idx = lowest_set(pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            remaining_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // An all-zero vector is consumed without leaving IDLE.
                    if (in_valid && (req != '0)) begin
                        pending     <= req;
                        remaining_q <= popcount(req);
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        pending[scan_idx] <= 1'b0;
                        remaining_q       <= remaining_q - 1'b1;
                        if (remaining_q == 1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == SCAN);
        busy      = (state == SCAN);
        in_ready  = (state == IDLE) && !reset;
        idx       = out_valid ? scan_idx : '0;
        last      = out_valid && (remaining_q == 1);
        remaining = remaining_q;
    end

endmodule

// File: tb/tb_req_encoder64_6.sv
// Bench for req_encoder64_6: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_req_encoder64_6;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] req;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  idx;
    logic        last;
    logic [6:0]  remaining;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;
    int q[$];

    req_encoder64_6 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .last      (last),
        .remaining (remaining),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: the pending work is just the ascending list of set-bit indices.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_out_valid", out_valid, (q.size() != 0));
            chk("m_busy",      busy,      (q.size() != 0));
            chk("m_in_ready",  in_ready,  (!reset && q.size() == 0));
            chk("m_idx",       idx,       (q.size() != 0) ? q[0] : 0);
            chk("m_remaining", remaining, q.size());
            chk("m_last",      last,      (q.size() == 1));
            if (reset) begin
                q.delete();
            end else if (q.size() == 0) begin
                if (in_valid) begin
                    for (int i = 0; i < 64; i++) begin
                        if (req[i]) q.push_back(i);
                    end
                end
            end else if (out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_req();
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0: r = '0;
            1: r = 64'h1 << $urandom_range(0, 63);
            2: r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; req = '0;
        step();
        model_on = 1'b1;
        chk("rst_in_ready", in_ready, 0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready",  in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_idx",       idx, 0);
        chk("post_rst_last",      last, 0);
        chk("post_rst_remaining", remaining, 0);
        chk("post_rst_busy",      busy, 0);

        // Single bit
        in_valid = 1'b1; req = 64'h20; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_idx", idx, 5);
        chk("single_last", last, 1);
        chk("single_rem", remaining, 1);
        step();
        chk("single_idle_ready", in_ready, 1);
        chk("single_idle_valid", out_valid, 0);

        // Multi-bit ordering
        in_valid = 1'b1; req = 64'h8000_0000_0000_0101;
        step();
        in_valid = 1'b0;
        chk("multi_idx0", idx, 0);  chk("multi_rem0", remaining, 3); chk("multi_last0", last, 0);
        step();
        chk("multi_idx1", idx, 8);  chk("multi_rem1", remaining, 2); chk("multi_last1", last, 0);
        step();
        chk("multi_idx2", idx, 63); chk("multi_rem2", remaining, 1); chk("multi_last2", last, 1);
        step();
        chk("multi_done_busy", busy, 0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; req = 64'h6;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_idx", idx, 1);
            chk("bp_rem", remaining, 2);
            step();
        end
        chk("bp_idx_held", idx, 1);
        out_ready = 1'b1;
        step();
        chk("bp_idx_next", idx, 2);
        chk("bp_last", last, 1);
        step();

        // Zero vector
        in_valid = 1'b1; req = '0;
        step();
        chk("zero_in_ready", in_ready, 1);
        chk("zero_out_valid", out_valid, 0);
        chk("zero_busy", busy, 0);
        in_valid = 1'b0;
        step();

        // Full vector, with junk offered on the input during SCAN
        in_valid = 1'b1; req = '1;
        step();
        for (int i = 0; i < 64; i++) begin
            in_valid = (i != 63);
            req = {$urandom, $urandom};
            #1;
            chk("full_idx", idx, i);
            chk("full_rem", remaining, 64 - i);
            chk("full_in_ready", in_ready, 0);
            step();
        end
        chk("full_end_rem", remaining, 0);
        chk("full_end_ready", in_ready, 1);

        // Reset mid-operation
        in_valid = 1'b1; req = 64'h7;
        step();
        in_valid = 1'b0;
        chk("rmid_idx0", idx, 0);
        step();
        chk("rmid_idx1", idx, 1);
        step();
        chk("rmid_idx2", idx, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rmid_valid", out_valid, 0);
        chk("rmid_rem", remaining, 0);
        chk("rmid_busy", busy, 0);
        in_valid = 1'b1; req = 64'h10;
        step();
        in_valid = 1'b0;
        chk("rmid_new_idx", idx, 4);
        step();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = $urandom_range(0, 1);
            req       = rand_req();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 70; c++) step();

        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/req_encoder64_6.md
REQ_ENCODER64_6 -- requirements
Module: req_encoder64_6

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  a request vector is offered on req.
REQ-005 in_ready  output  1  the block can accept a vector this cycle.
REQ-006 req  input  64  request vector; bit i set means index i is requested.
REQ-007 out_valid  output  1  idx holds a valid encoded index.
REQ-008 out_ready  input  1  the consumer takes idx this cycle.
REQ-009 idx  output  6  binary index of the lowest pending set bit (inverse of the 6:64 decode).
REQ-010 last  output  1  idx is the final pending bit of the current vector.
REQ-011 remaining  output  7  number of set bits still pending, range 0..64.
REQ-012 busy  output  1  the FSM is in SCAN.

Function
REQ-013 The FSM SHALL have two states, IDLE and SCAN, and SHALL hold a 64-bit register named pending.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In SCAN, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 An input transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1.
REQ-017 On an input transfer with req≠0, pending SHALL load req, remaining SHALL load popcount(req), and the FSM SHALL go to SCAN.
REQ-018 On an input transfer with req=0, the vector SHALL be consumed and dropped, with no output and the FSM staying in IDLE.
REQ-019 Latency: out_valid SHALL rise in the first cycle after the accepting edge.
REQ-020 In SCAN, idx SHALL equal the lowest i with pending[i]=1, decoded combinationally from the registered pending.
REQ-021 last SHALL equal 1 exactly when remaining=1 and SHALL be 0 outside SCAN.
REQ-022 An output transfer SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-023 On an output transfer, pending[idx] SHALL clear and remaining SHALL decrement by 1.
REQ-024 If last=1 at an output transfer, the FSM SHALL return to IDLE, so the next vector is accepted no earlier than the following edge (no same-cycle turnaround).
REQ-025 While out_ready=0 in SCAN, idx, last, remaining and pending SHALL hold stable.
REQ-026 Changes on in_valid or req SHALL be ignored while in SCAN.
REQ-027 A full vector (all 64 bits set) SHALL emit indices 0..63 in ascending order over 64 transfers, with remaining reaching 0 exactly at return to IDLE.
REQ-028 At most one index SHALL be emitted per cycle, and each set bit SHALL be emitted exactly once.
REQ-029 busy SHALL equal (state==SCAN).
REQ-030 idx SHALL be 0 when out_valid=0.

Reset
REQ-031 On a rising edge with reset=1, the FSM SHALL enter IDLE, pending SHALL become 0, and remaining SHALL become 0.
REQ-032 While reset=1, in_ready SHALL be forced to 0.
REQ-033 After reset deasserts, the outputs SHALL be: out_valid=0, idx=0, last=0, remaining=0, busy=0, in_ready=1.
REQ-034 Reset asserted mid-SCAN SHALL abandon the pending bits with no further output, and reset SHALL take priority over any simultaneous transfer.

Verification
REQ-035 Single bit: req=64'h0000_0000_0000_0020 accepted, out_ready=1 -> next cycle out_valid=1, idx=5, last=1, remaining=1; one cycle later IDLE with in_ready=1.
REQ-036 Multi-bit ordering: req=64'h8000_0000_0000_0101, out_ready=1 -> idx sequence 0, 8, 63 on consecutive cycles; last=1 only on 63; remaining sequence 3, 2, 1.
REQ-037 Backpressure: req=64'h0000_0000_0000_0006, out_ready=0 for 3 cycles -> idx=1 held with remaining=2; out_ready=1 -> then idx=2, last=1.
REQ-038 Zero vector: req=0 with in_valid=1 -> in_ready stays 1, out_valid stays 0, busy stays 0.
REQ-039 Full vector: req=all ones -> 64 transfers with idx 0..63, remaining 64 down to 1, and in_ready=0 throughout SCAN.
REQ-040 Reset mid-operation: reset=1 after 2 of 3 indices have been emitted -> next cycle out_valid=0, remaining=0, busy=0; a new vector 64'h10 then yields idx=4.
